// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - VGA scanout of a 12-bit frame buffer with 2x pixel/line replication
module fb_scanout #(
  parameter int FB_W     = 320,
  parameter int FB_H     = 240,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter bit FLIP_Y   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [16:0] o_fb_addr,
  input  logic [11:0] i_fb_data,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_active,
  output logic        o_vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;

  logic          r_s1_vis;
  logic          r_s1_hsync;
  logic          r_s1_vsync;
  logic          r_s1_vbl;

  logic [16:0]   r_fb_addr;
  logic [3:0]    r_r;
  logic [3:0]    r_g;
  logic [3:0]    r_b;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_active;
  logic          r_vblank_start;

  logic          w_tick;
  logic          w_phase_b;
  logic          w_vis;
  logic [HW-2:0] w_x;
  logic [VW-2:0] w_y;
  logic [16:0]   w_row;
  logic [16:0]   w_addr;
  logic          w_hsync_n;
  logic          w_vsync_n;
  logic          w_vbl;

  assign w_tick    = (r_div == DIV_LAST);
  assign w_phase_b = (r_div == '0);
  assign w_vis     = (r_h < H_ACT_C) && (r_v < V_ACT_C);

  // Halving h and v gives the 2x replication: odd h re-issues the same address
  // and each frame-buffer row is fetched on two consecutive lines.
  assign w_x   = r_h[HW-1:1];
  assign w_y   = r_v[VW-1:1];
  assign w_row = FLIP_Y ? (17'(FB_H - 1) - 17'(w_y)) : 17'(w_y);

  // Constant multiply by FB_W; for 320 this reduces to (row<<8)+(row<<6).
  assign w_addr = (w_row * 17'(FB_W)) + 17'(w_x);

  assign w_hsync_n = !((r_h >= HS_BEG) && (r_h <= HS_END));
  assign w_vsync_n = !((r_v >= VS_BEG) && (r_v <= VS_END));
  assign w_vbl     = (r_h == '0) && (r_v == V_ACT_C);

  // Pixel-tick divider: free-running 0..CLK_DIV-1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // Phase A: raster counters advance on the tick; h and v wrap together at frame end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end
  end

  // Phase B: issue the read for the new raster position and capture its sync/visibility
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fb_addr  <= '0;
      r_s1_vis   <= 1'b0;
      r_s1_hsync <= 1'b1;
      r_s1_vsync <= 1'b1;
      r_s1_vbl   <= 1'b0;
    end else if (w_phase_b) begin
      if (w_vis) begin
        r_fb_addr <= w_addr;
      end
      r_s1_vis   <= w_vis;
      r_s1_hsync <= w_hsync_n;
      r_s1_vsync <= w_vsync_n;
      r_s1_vbl   <= w_vbl;
    end
  end

  // Phase C: on the next tick present read data and the matching sync, one tick behind the counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r            <= '0;
      r_g            <= '0;
      r_b            <= '0;
      r_hsync        <= 1'b1;
      r_vsync        <= 1'b1;
      r_active       <= 1'b0;
      r_vblank_start <= 1'b0;
    end else begin
      r_vblank_start <= w_tick && r_s1_vbl;
      if (w_tick) begin
        r_active <= r_s1_vis;
        r_hsync  <= r_s1_hsync;
        r_vsync  <= r_s1_vsync;
        if (r_s1_vis) begin
          r_r <= i_fb_data[11:8];
          r_g <= i_fb_data[7:4];
          r_b <= i_fb_data[3:0];
        end else begin
          r_r <= '0;
          r_g <= '0;
          r_b <= '0;
        end
      end
    end
  end

  assign o_fb_addr      = r_fb_addr;
  assign o_r            = r_r;
  assign o_g            = r_g;
  assign o_b            = r_b;
  assign o_hsync        = r_hsync;
  assign o_vsync        = r_vsync;
  assign o_active       = r_active;
  assign o_vblank_start = r_vblank_start;

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - self-checking bench for fb_scanout against a tick-indexed raster model
module tb_fb_scanout;

  localparam int S_FBW = 16;
  localparam int S_FBH = 8;
  localparam int S_HA  = 32;
  localparam int S_HFP = 2;
  localparam int S_HS  = 4;
  localparam int S_HB  = 2;
  localparam int S_VA  = 16;
  localparam int S_VFP = 1;
  localparam int S_VS  = 2;
  localparam int S_VB  = 1;
  localparam int S_DIV = 3;

  typedef struct {
    int fbw; int fbh;
    int ha; int hfp; int hs; int hb;
    int va; int vfp; int vs; int vb;
    int d; int flip;
  } cfg_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] fb [0:76799];

  int n       = 0;
  int n_tests = 0;
  int n_fail  = 0;

  cfg_t c_full, c_small, c_flip0;

  logic [16:0] f_addr, s_addr, z_addr;
  logic [11:0] f_data, s_data, z_data;
  logic [3:0]  f_r, f_g, f_b, s_r, s_g, s_b, z_r, z_g, z_b;
  logic        f_hs, f_vs, f_act, f_vb;
  logic        s_hs, s_vs, s_act, s_vb;
  logic        z_hs, z_vs, z_act, z_vb;

  logic win   = 1'b0;
  logic blank = 1'b0;
  int   cnt_hs = 0, cnt_vs = 0, cnt_vb = 0;
  int   first_vb = -1;

  logic pl_fhs = 1'b0, pl_shs = 1'b0, pl_svs = 1'b0, pl_svb = 1'b0;
  int   tf_fhs = -1, tf_shs = -1, tf_svs = -1, tf_svb = -1;

  // Synchronous read port: data one clk after the address
  always @(posedge clk) begin
    f_data <= fb[f_addr];
    s_data <= fb[s_addr];
    z_data <= fb[z_addr];
  end

  fb_scanout u_full (
    .clk(clk), .rst_n(rst_n), .o_fb_addr(f_addr), .i_fb_data(f_data),
    .o_r(f_r), .o_g(f_g), .o_b(f_b), .o_hsync(f_hs), .o_vsync(f_vs),
    .o_active(f_act), .o_vblank_start(f_vb)
  );

  fb_scanout #(
    .FB_W(S_FBW), .FB_H(S_FBH), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VB), .CLK_DIV(S_DIV), .FLIP_Y(1'b1)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .o_fb_addr(s_addr), .i_fb_data(s_data),
    .o_r(s_r), .o_g(s_g), .o_b(s_b), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_active(s_act), .o_vblank_start(s_vb)
  );

  fb_scanout #(
    .FB_W(S_FBW), .FB_H(S_FBH), .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VB), .CLK_DIV(S_DIV), .FLIP_Y(1'b0)
  ) u_flip0 (
    .clk(clk), .rst_n(rst_n), .o_fb_addr(z_addr), .i_fb_data(z_data),
    .o_r(z_r), .o_g(z_g), .o_b(z_b), .o_hsync(z_hs), .o_vsync(z_vs),
    .o_active(z_act), .o_vblank_start(z_vb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  function automatic logic [16:0] addr_of(input cfg_t c, input int h, input int v);
    int row;
    row = (c.flip != 0) ? (c.fbh - 1 - v / 2) : (v / 2);
    return 17'(row * c.fbw + h / 2);
  endfunction

  // Expected outputs after the n-th clk edge since reset release (n=0: in reset)
  task automatic model(input cfg_t c, input int nn, output logic [16:0] ea, output logic [11:0] ergb,
                       output logic ehs, output logic evs, output logic eact, output logic evb);
    int ht, vt, k, h, v;
    ht = c.ha + c.hfp + c.hs + c.hb;
    vt = c.va + c.vfp + c.vs + c.vb;
    ea = '0; ergb = '0; ehs = 1'b1; evs = 1'b1; eact = 1'b0; evb = 1'b0;
    if (nn >= 1) begin
      k = (nn - 1) / c.d;
      h = k % ht;
      v = (k / ht) % vt;
      if (v >= c.va) begin
        h = c.ha - 1;
        v = c.va - 1;
      end else if (h >= c.ha) begin
        h = c.ha - 1;
      end
      ea = addr_of(c, h, v);
    end
    if (nn >= c.d) begin
      k = nn / c.d - 1;
      h = k % ht;
      v = (k / ht) % vt;
      eact = (h < c.ha) && (v < c.va);
      ergb = eact ? fb[addr_of(c, h, v)] : 12'h000;
      ehs  = !((h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs));
      evs  = !((v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs));
      evb  = ((nn % c.d) == 0) && (h == 0) && (v == c.va);
    end
  endtask

  task automatic check_inst(input string nm, input cfg_t c, input logic [16:0] a, input logic [11:0] rgb,
                            input logic hs, input logic vs, input logic act, input logic vb);
    logic [16:0] ea;
    logic [11:0] ergb;
    logic ehs, evs, eact, evb;
    model(c, n, ea, ergb, ehs, evs, eact, evb);
    chk({nm, ".addr"},   32'(a),   32'(ea));
    chk({nm, ".rgb"},    32'(rgb), 32'(ergb));
    chk({nm, ".hsync"},  32'(hs),  32'(ehs));
    chk({nm, ".vsync"},  32'(vs),  32'(evs));
    chk({nm, ".active"}, 32'(act), 32'(eact));
    chk({nm, ".vblank"}, 32'(vb),  32'(evb));
  endtask

  task automatic track(input string tag, input logic on, inout logic prev_on, inout int t_start,
                       input int width, input int period);
    if (on && !prev_on) begin
      if (t_start >= 0) chk({tag, ".period"}, 32'(n - t_start), 32'(period));
      t_start = n;
    end else if (!on && prev_on && t_start >= 0) begin
      chk({tag, ".width"}, 32'(n - t_start), 32'(width));
    end
    prev_on = on;
  endtask

  task automatic step();
    logic rs;
    rs = rst_n;
    @(posedge clk);
    #1;
    if (!rs) n = 0; else n++;
    if (n == 0) begin
      tf_fhs = -1; tf_shs = -1; tf_svs = -1; tf_svb = -1;
    end
    check_inst("full",  c_full,  f_addr, {f_r, f_g, f_b}, f_hs, f_vs, f_act, f_vb);
    check_inst("small", c_small, s_addr, {s_r, s_g, s_b}, s_hs, s_vs, s_act, s_vb);
    check_inst("flip0", c_flip0, z_addr, {z_r, z_g, z_b}, z_hs, z_vs, z_act, z_vb);
    track("full.hsync",   !f_hs, pl_fhs, tf_fhs, 384, 3200);
    track("small.hsync",  !s_hs, pl_shs, tf_shs, S_HS * S_DIV, 40 * S_DIV);
    track("small.vsync",  !s_vs, pl_svs, tf_svs, S_VS * 40 * S_DIV, 800 * S_DIV);
    track("small.vblank", s_vb,  pl_svb, tf_svb, 1, 800 * S_DIV);
    if (win && n >= 1 && n <= 1600 * S_DIV) begin
      if (!s_hs) cnt_hs++;
      if (!s_vs) cnt_vs++;
      if (s_vb)  cnt_vb++;
    end
    if (blank) begin
      chk("full.blank",  32'({f_r, f_g, f_b}), f_act ? 32'h0FFF : 32'h0);
      chk("small.blank", 32'({s_r, s_g, s_b}), s_act ? 32'h0FFF : 32'h0);
    end
  endtask

  initial begin
    c_full  = '{320, 240, 640, 16, 96, 48, 480, 10, 2, 33, 4, 1};
    c_small = '{S_FBW, S_FBH, S_HA, S_HFP, S_HS, S_HB, S_VA, S_VFP, S_VS, S_VB, S_DIV, 1};
    c_flip0 = '{S_FBW, S_FBH, S_HA, S_HFP, S_HS, S_HB, S_VA, S_VFP, S_VS, S_VB, S_DIV, 0};
    for (int a = 0; a < 76800; a++) fb[a] = 12'($urandom);

    // Reset held for 5 clk
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("rst.addr",   32'(f_addr), 32'd0);
    chk("rst.rgb",    32'({f_r, f_g, f_b}), 32'd0);
    chk("rst.hsync",  32'(f_hs),  32'd1);
    chk("rst.vsync",  32'(f_vs),  32'd1);
    chk("rst.active", 32'(f_act), 32'd0);
    chk("rst.vblank", 32'(f_vb),  32'd0);

    // Free run: address walk, replication, latency, sync timing
    rst_n = 1'b1;
    win   = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (n == 1) begin
        chk("full.first_addr",  32'(f_addr), 32'd76480);
        chk("small.first_addr", 32'(s_addr), 32'd112);
        chk("flip0.first_addr", 32'(z_addr), 32'd0);
      end
      if (n == 3)    chk("full.active_early", 32'(f_act), 32'd0);
      if (n == 4)    chk("full.active_rise",  32'(f_act), 32'd1);
      if (n == 2557) chk("full.line0_end",    32'(f_addr), 32'd76799);
      if (n == 3201) chk("full.line1_start",  32'(f_addr), 32'd76480);
      if (n == 6401) chk("full.line2_start",  32'(f_addr), 32'd76160);
      if (n == 590 * S_DIV + 1) chk("flip0.corner", 32'(z_addr), 32'd127);
    end
    win = 1'b0;
    chk("small.hsync_low_clks", 32'(cnt_hs), 32'(2 * 20 * S_HS * S_DIV));
    chk("small.vsync_low_clks", 32'(cnt_vs), 32'(2 * S_VS * 40 * S_DIV));
    chk("small.vblank_pulses",  32'(cnt_vb), 32'd2);

    // All-white frame buffer, then a one-clk reset in mid-frame
    rst_n = 1'b0;
    for (int a = 0; a < 76800; a++) fb[a] = 12'hFFF;
    blank = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < (8 * 40 + 15) * S_DIV; i++) step();
    rst_n = 1'b0;
    step();
    chk("midrst.addr",   32'(s_addr), 32'd0);
    chk("midrst.rgb",    32'({s_r, s_g, s_b}), 32'd0);
    chk("midrst.hsync",  32'(s_hs),  32'd1);
    chk("midrst.active", 32'(s_act), 32'd0);
    chk("midrst.vblank", 32'(s_vb),  32'd0);
    rst_n = 1'b1;
    first_vb = -1;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (n == 1) chk("midrst.restart_addr", 32'(f_addr), 32'd76480);
      if (s_vb && first_vb < 0) first_vb = n;
    end
    chk("midrst.first_vblank", 32'(first_vb), 32'((S_VA * 40 + 1) * S_DIV));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
